serial_alu_sequencer: RTL and testbench
=======================================

// Module: serial_alu_sequencer
// PURPOSE
//  Bit-serial add/increment/subtract controller built around a 1-bit full-adder cell with a carry flop.
//  Accepts WIDTH-bit operands on a valid/ready handshake and feeds the cell one bit pair per cycle, LSB first.
//  Collects sum bits in a shift register and presents the result on a valid/ready output handshake.
//  Sits between the operand-issue logic and the result consumer in place of a parallel WIDTH-bit adder.
// PARAMETERS
//  WIDTH    8   operand/result width in bits (>=1)
// PORTS
//  clk        in   1      single clock, rising edge
//  rst_n      in   1      asynchronous, active-low reset
//  in_valid   in   1      operand request
//  in_ready   out  1      block can accept a request (IDLE)
//  op         in   2      00 ADD a+b; 01 ADD_INC a+b+1; 10 INC a+1; 11 SUB a-b
//  a          in   WIDTH  operand A
//  b          in   WIDTH  operand B (ignored for INC)
//  out_valid  out  1      result available
//  out_ready  in   1      consumer takes result
//  sum        out  WIDTH  result, modulo 2^WIDTH
//  cout       out  1      carry out of MSB (SUB: 1 = no borrow)
//  ovf        out  1      signed overflow = carry into MSB ^ carry out of MSB
//  busy       out  1      high in RUN or DONE
// BEHAVIOUR
//  Reset (rst_n=0, async): state=IDLE, bit counter=0, carry=0, sum=0, cout=0, ovf=0, out_valid=0, busy=0.
//   in_ready = (state==IDLE), so it reads 1 during and after reset.
//  States: IDLE -> RUN on in_valid&&in_ready; RUN -> DONE when bit counter==WIDTH-1;
//   DONE -> IDLE on out_valid&&out_ready.
//  Accept edge: capture a; capture b_eff = b (ADD, ADD_INC), 0 (INC), ~b (SUB).
//   Carry flop loads cin = 0 (ADD) or 1 (ADD_INC, INC, SUB). Counter loads 0.
//  RUN, per edge:
//   - Cell computes s = a[0]^b_eff[0]^carry and c = majority(a[0], b_eff[0], carry).
//   - s shifts into sum MSB; a and b_eff shift right; carry <= c; counter++.
//   - On the last bit, cout <= c and ovf <= carry ^ c (carry here is the carry into the MSB).
//  Latency: out_valid rises exactly WIDTH edges after the accepting edge.
//   sum, cout and ovf are valid and stable while out_valid=1.
//  out_valid=1 only in DONE. Holds with all outputs frozen until out_ready=1.
//   The handshake edge returns the block to IDLE. sum/cout/ovf keep their last value until the next result.
//  in_valid while busy: ignored, no capture. Requester must hold its request until in_ready.
//  No overlap: in_ready=0 in DONE, so a new request is accepted no earlier than the cycle after the output handshake.
//  Wrap-around: results are modulo 2^WIDTH; carry is reported only via cout.
//  WIDTH=1: RUN lasts one cycle; ovf = cin ^ cout.
//  Reset mid-operation: abort immediately. Partial result is discarded and the reset values apply.
//  op/a/b are sampled only at the accept edge; later changes have no effect on the operation in flight.
// TESTING (WIDTH=8)
//  ADD a=0x3C b=0x05 -> out_valid 8 edges after accept; sum=0x41, cout=0, ovf=0.
//  ADD_INC a=0xFF b=0x00 -> sum=0x00, cout=1, ovf=0. ADD a=0x80 b=0x80 -> sum=0x00, cout=1, ovf=1.
//  INC a=0x7F (b=0xAA ignored) -> sum=0x80, cout=0, ovf=1. SUB a=0x05 b=0x07 -> sum=0xFE, cout=0, ovf=0.
//  Backpressure: out_ready=0 for 5 cycles -> out_valid and sum stable; in_ready=0; in_valid pulses ignored.
//   Then out_ready=1 -> IDLE next edge, in_ready=1.
//  Mid-RUN change: after accept of ADD 0x01+0x01, drive a=0xFF, op=11 during RUN -> result still 0x02.
//  Reset: rst_n low on 4th RUN cycle -> all outputs 0 immediately, in_ready=1.
//   After release, ADD 0x10+0x20 -> sum=0x30.

Source files
------------

// File: rtl/serial_alu_sequencer.sv
// serial_alu_sequencer: bit-serial add/inc/sub engine around a 1-bit full adder with a carry flop,
// fed LSB first from captured operands and wrapped in valid/ready handshakes on both sides.
module serial_alu_sequencer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             busy
);
    localparam int CW = WIDTH > 1 ? $clog2(WIDTH) : 1;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d, cout_q, cout_d, ovf_q, ovf_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sh_q, sh_d, sum_q, sum_d;
    logic             s, c, last;
    logic [WIDTH-1:0] sh_next;
    assign s        = a_q[0] ^ b_q[0] ^ carry_q;
    assign c        = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);
    assign last     = cnt_q == CW'(WIDTH - 1);
    assign sh_next  = WIDTH'({s, sh_q} >> 1);
    assign in_ready = state_q == IDLE;
    assign busy     = state_q != IDLE;
    assign out_valid = state_q == DONE;
    assign sum      = sum_q;
    assign cout     = cout_q;
    assign ovf      = ovf_q;
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        sh_d    = sh_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: if (in_valid) begin
                state_d = RUN;
                a_d     = a;
                b_d     = op == 2'b10 ? '0 : op == 2'b11 ? ~b : b;
                carry_d = op != 2'b00;
                cnt_d   = '0;
            end
            RUN: begin
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                carry_d = c;
                sh_d    = sh_next;
                cnt_d   = cnt_q + 1'b1;
                // the result registers only change when a full result is ready
                if (last) begin
                    state_d = DONE;
                    sum_d   = sh_next;
                    cout_d  = c;
                    ovf_d   = carry_q ^ c;
                end
            end
            DONE: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sh_q    <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sh_q    <= sh_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end
endmodule

// File: tb/tb_serial_alu_sequencer.sv
// tb_serial_alu_sequencer: arithmetic reference model compared every cycle, plus directed
// vectors with hand-computed results, backpressure, mid-run input changes and mid-run reset.
module tb_serial_alu_sequencer;
    localparam int W = 8;
    logic clk = 1'b0, rst_n, in_valid, in_ready, out_valid, out_ready, cout, ovf, busy;
    logic [1:0] op;
    logic [W-1:0] a, b, sum;
    int checks = 0, failures = 0;
    serial_alu_sequencer #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .op(op), .a(a), .b(b),
        .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf), .busy(busy)
    );
    always #5 clk = ~clk;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask
    function automatic logic [W+1:0] model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        logic [W-1:0] be;
        logic [W:0] full;
        logic v;
        be   = o == 2'd2 ? '0 : o == 2'd3 ? ~y : y;
        full = {1'b0, x} + {1'b0, be} + {{W{1'b0}}, o != 2'd0};
        v    = (x[W-1] == be[W-1]) && (full[W-1] != x[W-1]);
        return {v, full};
    endfunction
    int m_ph, m_left;
    logic [W+1:0] p_res, m_res;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ph <= 0; m_left <= 0; m_res <= '0; p_res <= '0;
        end else if (m_ph == 0) begin
            if (in_valid) begin m_ph <= 1; m_left <= W; p_res <= model(op, a, b); end
        end else if (m_ph == 1) begin
            m_left <= m_left - 1;
            if (m_left == 1) begin m_ph <= 2; m_res <= p_res; end
        end else if (out_ready) m_ph <= 0;
    end
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_outputs", {in_ready, out_valid, busy, cout, ovf, sum}, {5'b10000, 8'h00});
        end else begin
            chk("in_ready", in_ready, m_ph == 0);
            chk("busy", busy, m_ph != 0);
            chk("out_valid", out_valid, m_ph == 2);
            chk("result", {ovf, cout, sum}, m_res);
        end
    end
    task automatic do_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic [W-1:0] es, input logic ec, input logic eo, input int bp, input bit scr);
        int cyc;
        @(posedge clk); #1;
        in_valid = 1'b1; op = o; a = x; b = y;
        @(posedge clk); #1;
        in_valid = 1'b0;
        if (scr) begin op = 2'b11; a = 8'hFF; b = 8'h55; end
        cyc = 0;
        while (!out_valid && cyc < 50) begin @(posedge clk); #1; cyc++; end
        chk("latency", cyc, W);
        chk("sum", sum, es);
        chk("cout", cout, ec);
        chk("ovf", ovf, eo);
        for (int i = 0; i < bp; i++) begin
            in_valid = i[0];
            op = 2'b01; a = 8'h11; b = 8'h22;
            @(posedge clk); #1;
            chk("bp_hold", {out_valid, in_ready, sum}, {2'b10, es});
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("handshake_idle", {in_ready, out_valid, busy}, 3'b100);
    endtask
    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; op = '0; a = '0; b = '0;
        #1 chk("reset_state", {in_ready, out_valid, busy, sum}, {3'b100, 8'h00});
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        do_op(2'b00, 8'h3C, 8'h05, 8'h41, 1'b0, 1'b0, 0, 1'b0);
        do_op(2'b01, 8'hFF, 8'h00, 8'h00, 1'b1, 1'b0, 0, 1'b0);
        do_op(2'b00, 8'h80, 8'h80, 8'h00, 1'b1, 1'b1, 0, 1'b0);
        do_op(2'b10, 8'h7F, 8'hAA, 8'h80, 1'b0, 1'b1, 0, 1'b0);
        do_op(2'b11, 8'h05, 8'h07, 8'hFE, 1'b0, 1'b0, 5, 1'b0);
        do_op(2'b11, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b1, 0, 1'b0);
        do_op(2'b00, 8'h01, 8'h01, 8'h02, 1'b0, 1'b0, 0, 1'b1);
        @(posedge clk); #1;
        in_valid = 1'b1; op = 2'b00; a = 8'h55; b = 8'h11;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        #1 chk("midrun_reset", {in_ready, out_valid, busy, cout, ovf, sum}, {5'b10000, 8'h00});
        @(posedge clk); #1 rst_n = 1'b1;
        do_op(2'b00, 8'h10, 8'h20, 8'h30, 1'b0, 1'b0, 0, 1'b0);
        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
    initial begin
        #100000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end
endmodule
